aes128_block_packer: RTL and testbench

AES128_BLOCK_PACKER -- requirements
Module: aes128_block_packer

---
 rtl/aes128_block_packer.sv | 113 +++++++++++
 tb/tb_aes128_block_packer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_block_packer.sv
// Byte-stream to 128-bit AES plaintext block packer.
// The final block is either PKCS#7 padded or zero-filled, depending on PAD_EN.
module aes128_block_packer #(
    parameter bit PAD_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_byte,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [0:127] blk_data,
    output logic         blk_valid,
    output logic         blk_last,
    input  logic         blk_ready,
    output logic [3:0]   fill_cnt
);

    typedef enum logic [1:0] {FILL, OUT, PADBLK} state_t;

    state_t       state;
    state_t       state_next;
    logic [0:127] data_next;
    logic [3:0]   cnt_next;
    logic         last_next;
    logic         pad_pending;
    logic         pad_next;
    logic         byte_take;
    logic [7:0]   fill_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            blk_data    <= '0;
            fill_cnt    <= 4'd0;
            blk_last    <= 1'b0;
            pad_pending <= 1'b0;
        end else begin
            state       <= state_next;
            blk_data    <= data_next;
            fill_cnt    <= cnt_next;
            blk_last    <= last_next;
            pad_pending <= pad_next;
        end
    end

    always_comb begin
        state_next = state;
        data_next  = blk_data;
        cnt_next   = fill_cnt;
        last_next  = blk_last;
        pad_next   = pad_pending;
        in_ready   = 1'b0;
        blk_valid  = 1'b0;
        byte_take  = 1'b0;
        // PKCS#7 pad value is 16-(k+1) = 15-k, which is simply the inverse of the 4-bit index.
        fill_val   = PAD_EN ? {4'h0, ~fill_cnt} : 8'h00;

        case (state)
            FILL: begin
                in_ready  = !rst;
                byte_take = in_valid && !rst;
                if (byte_take) begin
                    data_next[{fill_cnt, 3'b000} +: 8] = in_byte;
                    if (in_last) begin
                        for (int j = 0; j < 16; j++) begin
                            if (j > int'(fill_cnt)) begin
                                data_next[8*j +: 8] = fill_val;
                            end
                        end
                    end
                    if (fill_cnt == 4'd15 || in_last) begin
                        state_next = OUT;
                        cnt_next   = 4'd0;
                        // A message ending exactly on a block boundary needs a whole extra pad block.
                        last_next  = in_last && (!PAD_EN || fill_cnt != 4'd15);
                        pad_next   = in_last && PAD_EN && fill_cnt == 4'd15;
                    end else begin
                        cnt_next = fill_cnt + 4'd1;
                    end
                end
            end

            OUT: begin
                blk_valid = 1'b1;
                if (blk_ready) begin
                    if (pad_pending) begin
                        data_next  = {16{8'h10}};
                        last_next  = 1'b1;
                        pad_next   = 1'b0;
                        state_next = PADBLK;
                    end else begin
                        last_next  = 1'b0;
                        state_next = FILL;
                    end
                end
            end

            PADBLK: begin
                blk_valid = 1'b1;
                if (blk_ready) begin
                    last_next  = 1'b0;
                    state_next = FILL;
                end
            end

            default: begin
                state_next = FILL;
            end
        endcase
    end

endmodule

// File: tb/tb_aes128_block_packer.sv
// Self-checking bench for aes128_block_packer: directed vectors, stall/reset sequences
// and randomized messages compared against a PKCS#7 block model.
module tb_aes128_block_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [0:127] blk_data;
    logic         blk_valid;
    logic         blk_last;
    logic         blk_ready;
    logic [3:0]   fill_cnt;

    logic [7:0]   in_byte0;
    logic         in_valid0;
    logic         in_last0;
    logic         in_ready0;
    logic [0:127] blk_data0;
    logic         blk_valid0;
    logic         blk_last0;
    logic         blk_ready0;
    logic [3:0]   fill_cnt0;

    int tests_run  = 0;
    int fail_count = 0;

    logic [7:0]   tx_q[$];
    logic [127:0] got_data[$];
    logic         got_last[$];
    logic [127:0] exp_data[$];
    logic         exp_last[$];

    typedef struct packed {
        logic [127:0] d0;
        logic         l0;
        logic [127:0] d1;
        logic         l1;
        logic [1:0]   nblk;
    } vec_t;

    vec_t  vecs[4];
    string vec_msg[4];

    aes128_block_packer #(.PAD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .blk_data(blk_data), .blk_valid(blk_valid), .blk_last(blk_last),
        .blk_ready(blk_ready), .fill_cnt(fill_cnt)
    );

    aes128_block_packer #(.PAD_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_byte(in_byte0), .in_valid(in_valid0), .in_last(in_last0),
        .in_ready(in_ready0), .blk_data(blk_data0), .blk_valid(blk_valid0), .blk_last(blk_last0),
        .blk_ready(blk_ready0), .fill_cnt(fill_cnt0)
    );

    always #5 clk = ~clk;

    // Handshake inputs change just after the rising edge, so the falling edge sees the settled transfer.
    always @(negedge clk) begin
        if (!rst && blk_valid && blk_ready) begin
            got_data.push_back(blk_data);
            got_last.push_back(blk_last);
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic checkBlock(input string name, input int k);
        if (got_data.size() > k) begin
            checkOutput({name, "_data"}, got_data[k], exp_data[k]);
            checkOutput({name, "_last"}, 128'(got_last[k]), 128'(exp_last[k]));
        end else begin
            checkOutput({name, "_missing"}, 128'(got_data.size()), 128'(k + 1));
        end
    endtask

    task automatic loadString(input string s);
        tx_q.delete();
        for (int i = 0; i < s.len(); i++) tx_q.push_back(s[i]);
    endtask

    task automatic clearCapture();
        got_data.delete();
        got_last.delete();
        exp_data.delete();
        exp_last.delete();
    endtask

    // Reference: append PKCS#7 padding to the whole message, then cut into 16-byte blocks.
    task automatic buildExpected();
        logic [7:0]   m[$];
        logic [127:0] w;
        int           pad;
        int           nb;
        m   = tx_q;
        pad = 16 - (m.size() % 16);
        repeat (pad) m.push_back(8'(pad));
        nb = m.size() / 16;
        exp_data.delete();
        exp_last.delete();
        for (int b = 0; b < nb; b++) begin
            w = '0;
            for (int j = 0; j < 16; j++) w = {w[119:0], m[16*b + j]};
            exp_data.push_back(w);
            exp_last.push_back(b == nb - 1);
        end
    endtask

    // ready_mode: 0 = blk_ready high, 1 = random, 2 = blk_ready low
    task automatic applyStimulus(input int gap_pct, input int ready_mode, input bit with_last);
        int i;
        int guard;
        bit accepted;
        i = 0;
        guard = 0;
        while (i < tx_q.size() && guard < 4000) begin
            if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                in_byte  = 8'($urandom);
                in_last  = 1'($urandom);
            end else begin
                in_valid = 1'b1;
                in_byte  = tx_q[i];
                in_last  = with_last && (i == tx_q.size() - 1);
            end
            if (ready_mode == 1) blk_ready = (int'($urandom_range(99)) < 60);
            else                 blk_ready = (ready_mode == 0);
            accepted = in_valid && in_ready;
            @(posedge clk); #1;
            if (accepted) i++;
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkOutput("send_done", 128'(i), 128'(tx_q.size()));
    endtask

    task automatic waitBlocks(input int n, input int ready_mode);
        int guard;
        guard = 0;
        while (guard < 500 && !(got_data.size() >= n && !blk_valid)) begin
            if (ready_mode == 1) blk_ready = (int'($urandom_range(99)) < 60);
            else                 blk_ready = (ready_mode == 0);
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("blk_count", 128'(got_data.size()), 128'(n));
    endtask

    initial begin
        int len;

        rst = 1'b1;
        in_byte = 8'h00; in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b0;
        in_byte0 = 8'h00; in_valid0 = 1'b0; in_last0 = 1'b0; blk_ready0 = 1'b0;

        vec_msg[0] = "sentence2encrypt";
        vecs[0] = '{d0: 128'h73656e74656e636532656e6372797074, l0: 1'b0,
                    d1: 128'h10101010101010101010101010101010, l1: 1'b1, nblk: 2'd2};
        vec_msg[1] = "password123";
        vecs[1] = '{d0: 128'h70617373776f72643132330505050505, l0: 1'b1,
                    d1: 128'h0, l1: 1'b0, nblk: 2'd1};
        vec_msg[2] = "abcdefghijklmno";
        vecs[2] = '{d0: 128'h6162636465666768696a6b6c6d6e6f01, l0: 1'b1,
                    d1: 128'h0, l1: 1'b0, nblk: 2'd1};
        vec_msg[3] = "ABCDEFGHIJKLMNOPQ";
        vecs[3] = '{d0: 128'h4142434445464748494a4b4c4d4e4f50, l0: 1'b0,
                    d1: 128'h510f0f0f0f0f0f0f0f0f0f0f0f0f0f0f, l1: 1'b1, nblk: 2'd2};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 128'(in_ready), 128'd0);
        checkOutput("rst_blk_valid", 128'(blk_valid), 128'd0);
        checkOutput("rst_blk_last", 128'(blk_last), 128'd0);
        checkOutput("rst_fill_cnt", 128'(fill_cnt), 128'd0);
        checkOutput("rst_blk_data", blk_data, 128'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 128'(in_ready), 128'd1);

        // Table-driven messages
        for (int v = 0; v < 4; v++) begin
            loadString(vec_msg[v]);
            clearCapture();
            exp_data.push_back(vecs[v].d0);
            exp_last.push_back(vecs[v].l0);
            if (vecs[v].nblk == 2'd2) begin
                exp_data.push_back(vecs[v].d1);
                exp_last.push_back(vecs[v].l1);
            end
            applyStimulus(0, 0, 1'b1);
            waitBlocks(int'(vecs[v].nblk), 0);
            for (int k = 0; k < exp_data.size(); k++) checkBlock(vec_msg[v], k);
        end

        // Pad block follows the full block with no idle cycle
        loadString("sentence2encrypt");
        clearCapture();
        applyStimulus(0, 0, 1'b1);
        checkOutput("lat_valid0", 128'(blk_valid), 128'd1);
        checkOutput("lat_data0", blk_data, 128'h73656e74656e636532656e6372797074);
        checkOutput("lat_last0", 128'(blk_last), 128'd0);
        @(posedge clk); #1;
        checkOutput("lat_valid1", 128'(blk_valid), 128'd1);
        checkOutput("lat_data1", blk_data, 128'h10101010101010101010101010101010);
        checkOutput("lat_last1", 128'(blk_last), 128'd1);
        checkOutput("lat_in_ready1", 128'(in_ready), 128'd0);
        @(posedge clk); #1;
        checkOutput("lat_valid2", 128'(blk_valid), 128'd0);
        checkOutput("lat_in_ready2", 128'(in_ready), 128'd1);

        // Downstream stall holds the block and blocks input
        loadString("0123456789abcdef");
        clearCapture();
        applyStimulus(0, 2, 1'b0);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_byte  = 8'hEE;
            checkOutput("stall_valid", 128'(blk_valid), 128'd1);
            checkOutput("stall_data", blk_data, 128'h30313233343536373839616263646566);
            checkOutput("stall_last", 128'(blk_last), 128'd0);
            checkOutput("stall_in_ready", 128'(in_ready), 128'd0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        blk_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("stall_release_valid", 128'(blk_valid), 128'd0);
        checkOutput("stall_release_in_ready", 128'(in_ready), 128'd1);
        checkOutput("stall_release_fill", 128'(fill_cnt), 128'd0);
        checkOutput("stall_count", 128'(got_data.size()), 128'd1);

        // Gaps ignore in_last, then reset discards the partial block
        loadString("ABCDEFG");
        clearCapture();
        applyStimulus(0, 0, 1'b0);
        checkOutput("partial_fill", 128'(fill_cnt), 128'd7);
        in_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_last = 1'b0;
        checkOutput("gap_fill", 128'(fill_cnt), 128'd7);
        checkOutput("gap_valid", 128'(blk_valid), 128'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_fill", 128'(fill_cnt), 128'd0);
        checkOutput("midrst_in_ready", 128'(in_ready), 128'd0);
        checkOutput("midrst_data", blk_data, 128'd0);
        rst = 1'b0;
        #1;
        loadString("sentence2encrypt");
        clearCapture();
        exp_data.push_back(128'h73656e74656e636532656e6372797074);
        exp_last.push_back(1'b0);
        applyStimulus(0, 0, 1'b0);
        waitBlocks(1, 0);
        checkBlock("after_rst", 0);

        // Reset while a block is held drops it
        loadString("fedcba9876543210");
        clearCapture();
        applyStimulus(0, 2, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("outrst_valid", 128'(blk_valid), 128'd0);
        waitBlocks(0, 0);

        // Zero-fill variant
        blk_ready0 = 1'b1;
        in_byte0 = 8'h41; in_valid0 = 1'b1; in_last0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0; in_last0 = 1'b0;
        checkOutput("zf1_valid", 128'(blk_valid0), 128'd1);
        checkOutput("zf1_data", blk_data0, 128'h41000000000000000000000000000000);
        checkOutput("zf1_last", 128'(blk_last0), 128'd1);
        @(posedge clk); #1;
        checkOutput("zf1_done", 128'(blk_valid0), 128'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("zf1_no_extra", 128'(blk_valid0), 128'd0);
        for (int i = 0; i < 16; i++) begin
            in_byte0  = 8'(8'h60 + i);
            in_valid0 = 1'b1;
            in_last0  = (i == 15);
            @(posedge clk); #1;
        end
        in_valid0 = 1'b0; in_last0 = 1'b0;
        checkOutput("zf16_valid", 128'(blk_valid0), 128'd1);
        checkOutput("zf16_data", blk_data0, 128'h606162636465666768696a6b6c6d6e6f);
        checkOutput("zf16_last", 128'(blk_last0), 128'd1);
        @(posedge clk); #1;
        checkOutput("zf16_no_pad", 128'(blk_valid0), 128'd0);

        // Randomized messages with gaps on both sides
        for (int m = 0; m < 100; m++) begin
            len = int'($urandom_range(64, 1));
            tx_q.delete();
            for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom));
            got_data.delete();
            got_last.delete();
            buildExpected();
            applyStimulus(30, 1, 1'b1);
            waitBlocks(exp_data.size(), 1);
            for (int k = 0; k < exp_data.size(); k++) checkBlock("rand", k);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
